// File: rtl/sccb_target.sv
// sccb_target: SCCB target that answers an initiator like an emulated camera sensor
// Ports: clk_i       main clock (>= 20x SIOC)
//        rst_i       synchronous, active-low reset
//        sioc_i      SIOC from the initiator
//        siod_io     SIOD, open drain: driven 0 or left z
//        reg_addr_o  sub-address pointer, persists across transactions
//        reg_wdata_o write data, valid with reg_we_o
//        reg_we_o    one-clk write strobe
//        reg_re_o    one-clk read strobe for reg_addr_o
//        reg_rdata_i read data, sampled one clk after reg_re_o
//        busy_o      high while this device is addressed
module sccb_target #(
    parameter logic [6:0] DEV_ID     = 7'h21,
    parameter int         GLITCH_CYC = 3,
    parameter bit         AUTO_INC   = 1'b1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       sioc_i,
    inout  logic       siod_io,
    output logic [7:0] reg_addr_o,
    output logic [7:0] reg_wdata_o,
    output logic       reg_we_o,
    output logic       reg_re_o,
    input  logic [7:0] reg_rdata_i,
    output logic       busy_o
);
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] ID        = 3'd1;
    localparam logic [2:0] ACK       = 3'd2;
    localparam logic [2:0] SUBADDR   = 3'd3;
    localparam logic [2:0] WDATA     = 3'd4;
    localparam logic [2:0] RDATA     = 3'd5;
    localparam logic [2:0] RDATA_ACK = 3'd6;
    localparam logic [2:0] IGNORE    = 3'd7;
    localparam logic [3:0] GLITCH_MAX = 4'(GLITCH_CYC - 1);

    // bit 1 = SIOC, bit 0 = SIOD
    logic [1:0] raw, sync1_q, sync2_q, filt_q, prev_q;
    logic [3:0] stab_q [2];
    assign raw = {sioc_i, siod_io};

    // A filtered level only follows its synchronized input after GLITCH_CYC
    // consecutive samples that disagree with it.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            sync1_q   <= '1;
            sync2_q   <= '1;
            filt_q    <= '1;
            prev_q    <= '1;
            stab_q[0] <= '0;
            stab_q[1] <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            prev_q  <= filt_q;
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] == filt_q[i]) stab_q[i] <= '0;
                else if (stab_q[i] == GLITCH_MAX) begin
                    filt_q[i] <= sync2_q[i];
                    stab_q[i] <= '0;
                end else stab_q[i] <= stab_q[i] + 4'd1;
            end
        end
    end

    logic sda, rise, fall, start, stop;
    assign sda   = filt_q[0];
    assign rise  = filt_q[1] & ~prev_q[1];
    assign fall  = ~filt_q[1] & prev_q[1];
    assign start = filt_q[1] & prev_q[0] & ~filt_q[0];
    assign stop  = filt_q[1] & ~prev_q[0] & filt_q[0];

    logic [2:0] state_q, state_d, ret_q, ret_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] sh_q, sh_d, addr_q, addr_d, wdata_q, wdata_d, rx_byte;
    logic       drv_q, drv_d, ackon_q, ackon_d, inc_q, inc_d;
    logic       we_q, we_d, re_q, re_d, ld_q, busy_q, busy_d;

    assign rx_byte = {sh_q[6:0], sda};

    // ACK is shared by every byte phase: ret_q holds the phase to resume,
    // ackon_q marks that the ACK low is currently being driven.
    always_comb begin
        state_d = state_q;
        ret_d   = ret_q;
        cnt_d   = cnt_q;
        sh_d    = ld_q ? reg_rdata_i : sh_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        drv_d   = drv_q;
        ackon_d = ackon_q;
        inc_d   = inc_q;
        busy_d  = busy_q;
        we_d    = 1'b0;
        re_d    = 1'b0;
        if (start || stop) begin
            state_d = start ? ID : IDLE;
            cnt_d   = '0;
            drv_d   = 1'b0;
            ackon_d = 1'b0;
            inc_d   = 1'b0;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                ID, SUBADDR, WDATA: if (rise) begin
                    sh_d  = rx_byte;
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd7) begin
                        cnt_d   = '0;
                        state_d = ACK;
                        ackon_d = 1'b0;
                        if (state_q == ID) begin
                            if (rx_byte[7:1] == DEV_ID) begin
                                busy_d = 1'b1;
                                ret_d  = rx_byte[0] ? RDATA : SUBADDR;
                            end else state_d = IGNORE;
                        end else if (state_q == SUBADDR) begin
                            addr_d = rx_byte;
                            ret_d  = WDATA;
                        end else begin
                            wdata_d = rx_byte;
                            we_d    = 1'b1;
                            inc_d   = 1'b1;
                            ret_d   = WDATA;
                        end
                    end
                end
                ACK: if (fall) begin
                    if (!ackon_q) begin
                        drv_d   = 1'b1;
                        ackon_d = 1'b1;
                    end else begin
                        ackon_d = 1'b0;
                        inc_d   = 1'b0;
                        state_d = ret_q;
                        cnt_d   = '0;
                        drv_d   = (ret_q == RDATA) ? ~sh_q[7] : 1'b0;
                        sh_d    = (ret_q == RDATA) ? {sh_q[6:0], 1'b0} : sh_q;
                        addr_d  = inc_q ? addr_q + {7'd0, AUTO_INC} : addr_q;
                    end
                end else if (rise && ackon_q && ret_q == RDATA) re_d = 1'b1;
                RDATA: if (fall) begin
                    // the MSB already went out on the fall that ended the ACK
                    drv_d   = (cnt_q == 4'd8) ? 1'b0 : ~sh_q[7];
                    sh_d    = (cnt_q == 4'd8) ? sh_q : {sh_q[6:0], 1'b0};
                    state_d = (cnt_q == 4'd8) ? RDATA_ACK : RDATA;
                end else if (rise) cnt_d = cnt_q + 4'd1;
                RDATA_ACK: if (rise) begin
                    addr_d  = addr_q + {7'd0, AUTO_INC};
                    cnt_d   = '0;
                    re_d    = ~sda;
                    state_d = sda ? IGNORE : RDATA;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            ret_q   <= SUBADDR;
            cnt_q   <= '0;
            sh_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            drv_q   <= 1'b0;
            ackon_q <= 1'b0;
            inc_q   <= 1'b0;
            we_q    <= 1'b0;
            re_q    <= 1'b0;
            ld_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            drv_q   <= drv_d;
            ackon_q <= ackon_d;
            inc_q   <= inc_d;
            we_q    <= we_d;
            re_q    <= re_d;
            ld_q    <= re_q;
            busy_q  <= busy_d;
        end
    end

    assign siod_io     = drv_q ? 1'b0 : 1'bz;
    assign reg_addr_o  = addr_q;
    assign reg_wdata_o = wdata_q;
    assign reg_we_o    = we_q;
    assign reg_re_o    = re_q;
    assign busy_o      = busy_q;
endmodule

// File: tb/tb_sccb_target.sv
// tb_sccb_target: directed SCCB initiator driving sccb_target
module tb_sccb_target;
    logic       clk = 1'b0, rst_n = 1'b0, scl = 1'b1, sda_low = 1'b0;
    logic [7:0] reg_addr, reg_wdata, reg_rdata = 8'h00;
    logic       reg_we, reg_re, busy;
    wire        siod;
    int         n_vec = 0, n_err = 0;
    logic [7:0] we_a[$], we_d[$], re_a[$];
    logic       drv_seen = 1'b0, busy_seen = 1'b0;
    logic       a0, a1, a2;
    logic [7:0] rd, v;

    assign siod = sda_low ? 1'b0 : 1'bz;
    pullup (siod);
    always #5 clk = ~clk;

    sccb_target dut (
        .clk_i(clk), .rst_i(rst_n), .sioc_i(scl), .siod_io(siod),
        .reg_addr_o(reg_addr), .reg_wdata_o(reg_wdata), .reg_we_o(reg_we),
        .reg_re_o(reg_re), .reg_rdata_i(reg_rdata), .busy_o(busy)
    );

    always @(negedge clk) begin
        if (reg_we) begin
            we_a.push_back(reg_addr);
            we_d.push_back(reg_wdata);
        end
        if (reg_re) re_a.push_back(reg_addr);
        if (siod == 1'b0 && !sda_low) drv_seen = 1'b1;
        if (busy) busy_seen = 1'b1;
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_log();
        we_a.delete(); we_d.delete(); re_a.delete();
        drv_seen = 1'b0;
        busy_seen = 1'b0;
    endtask

    task automatic bus_start();
        sda_low = 1'b0; wclk(10);
        scl = 1'b1; wclk(20);
        sda_low = 1'b1; wclk(20);
        scl = 1'b0; wclk(10);
    endtask

    task automatic bus_stop();
        sda_low = 1'b1; wclk(10);
        scl = 1'b1; wclk(20);
        sda_low = 1'b0; wclk(20);
    endtask

    task automatic bit_out(input logic b);
        sda_low = ~b; wclk(10);
        scl = 1'b1; wclk(20);
        scl = 1'b0; wclk(10);
    endtask

    task automatic bit_in(output logic b);
        sda_low = 1'b0; wclk(10);
        scl = 1'b1; wclk(10);
        b = siod; wclk(10);
        scl = 1'b0; wclk(10);
    endtask

    task automatic wr_byte(input logic [7:0] d, output logic nack);
        for (int i = 7; i >= 0; i--) bit_out(d[i]);
        bit_in(nack);
    endtask

    task automatic rd_byte(input logic nack, output logic [7:0] d);
        for (int i = 7; i >= 0; i--) bit_in(d[i]);
        bit_out(nack);
    endtask

    initial begin
        wclk(5);
        check("rst_addr", 16'(reg_addr), 16'h00);
        check("rst_wdata", 16'(reg_wdata), 16'h00);
        check("rst_we", 16'(reg_we), 16'h0);
        check("rst_re", 16'(reg_re), 16'h0);
        check("rst_busy", 16'(busy), 16'h0);
        check("rst_siod", 16'(siod), 16'h1);
        rst_n = 1'b1; wclk(10);

        // 3-phase write
        clear_log();
        bus_start();
        wr_byte(8'h42, a0);
        check("w3_busy", 16'(busy), 16'h1);
        wr_byte(8'h12, a1);
        wr_byte(8'h80, a2);
        bus_stop();
        check("w3_acks", {13'd0, a0, a1, a2}, 16'h0);
        check("w3_we_cnt", 16'(we_a.size()), 16'd1);
        if (we_a.size() == 1) begin
            check("w3_we_addr", 16'(we_a[0]), 16'h12);
            check("w3_we_data", 16'(we_d[0]), 16'h80);
        end
        check("w3_addr_inc", 16'(reg_addr), 16'h13);
        check("w3_busy_end", 16'(busy), 16'h0);

        // 2-phase write then read
        clear_log();
        reg_rdata = 8'h76;
        bus_start();
        wr_byte(8'h42, a0);
        wr_byte(8'h0A, a1);
        bus_stop();
        check("r2_ptr", 16'(reg_addr), 16'h0A);
        bus_start();
        wr_byte(8'h43, a2);
        rd_byte(1'b1, rd);
        bus_stop();
        check("r2_acks", {13'd0, a0, a1, a2}, 16'h0);
        check("r2_re_cnt", 16'(re_a.size()), 16'd1);
        if (re_a.size() == 1) check("r2_re_addr", 16'(re_a[0]), 16'h0A);
        check("r2_data", 16'(rd), 16'h76);
        check("r2_no_we", 16'(we_a.size()), 16'd0);
        check("r2_addr_after", 16'(reg_addr), 16'h0B);

        // wrong device id
        clear_log();
        bus_start();
        wr_byte(8'h60, a0);
        wr_byte(8'h12, a1);
        wr_byte(8'h80, a2);
        bus_stop();
        check("wid_nacks", {13'd0, a0, a1, a2}, 16'h7);
        check("wid_drv", 16'(drv_seen), 16'h0);
        check("wid_strobes", 16'(we_a.size() + re_a.size()), 16'd0);
        check("wid_busy", 16'(busy_seen), 16'h0);

        // abort mid data byte, then a normal write
        clear_log();
        bus_start();
        wr_byte(8'h42, a0);
        wr_byte(8'h05, a1);
        bit_out(1'b1); bit_out(1'b0); bit_out(1'b1); bit_out(1'b0);
        bus_stop();
        check("ab_no_we", 16'(we_a.size()), 16'd0);
        check("ab_siod", 16'(siod), 16'h1);
        check("ab_busy", 16'(busy), 16'h0);
        check("ab_ptr", 16'(reg_addr), 16'h05);
        bus_start();
        wr_byte(8'h42, a0);
        wr_byte(8'h20, a1);
        wr_byte(8'h3C, a2);
        bus_stop();
        check("ab_next_acks", {13'd0, a0, a1, a2}, 16'h0);
        check("ab_next_we", 16'(we_a.size()), 16'd1);
        if (we_a.size() == 1) check("ab_next_wr", {we_a[0], we_d[0]}, 16'h203C);

        // reset while the target drives its ACK
        bus_start();
        v = 8'h42;
        for (int i = 7; i >= 0; i--) bit_out(v[i]);
        sda_low = 1'b0; wclk(10);
        scl = 1'b1; wclk(5);
        check("rs_ack_low", 16'(siod), 16'h0);
        rst_n = 1'b0; wclk(1);
        check("rs_siod_rel", 16'(siod), 16'h1);
        check("rs_addr", 16'(reg_addr), 16'h00);
        check("rs_busy", 16'(busy), 16'h0);
        wclk(10);
        rst_n = 1'b1; wclk(20);

        // short SIOC glitch inside the sub-address byte
        clear_log();
        v = 8'h34;
        bus_start();
        wr_byte(8'h42, a0);
        for (int i = 7; i >= 4; i--) bit_out(v[i]);
        scl = 1'b1; wclk(2);
        scl = 1'b0; wclk(10);
        for (int i = 3; i >= 0; i--) bit_out(v[i]);
        bit_in(a1);
        wr_byte(8'h99, a2);
        bus_stop();
        check("gl_acks", {13'd0, a0, a1, a2}, 16'h0);
        check("gl_we_cnt", 16'(we_a.size()), 16'd1);
        if (we_a.size() == 1) check("gl_wr", {we_a[0], we_d[0]}, 16'h3499);

        // pointer wrap
        clear_log();
        bus_start();
        wr_byte(8'h42, a0);
        wr_byte(8'hFF, a1);
        wr_byte(8'hAA, a2);
        wr_byte(8'h55, a0);
        bus_stop();
        check("wr_we_cnt", 16'(we_a.size()), 16'd2);
        if (we_a.size() == 2) begin
            check("wr_first", {we_a[0], we_d[0]}, 16'hFFAA);
            check("wr_second", {we_a[1], we_d[1]}, 16'h0055);
        end
        check("wr_addr_after", 16'(reg_addr), 16'h01);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
